// File: rtl/avg_rr_sched_if.sv
// Bundle between the round-robin scheduler, its requesters and the shared average engine.
// The slave view belongs to the scheduler; the master view is the requester/engine side.
interface avg_rr_sched_if #(
   parameter int unsigned NOF_BITS = 32,
   parameter int unsigned NREQ     = 4
);
   logic [NREQ-1:0]          req;
   logic [NREQ-1:0]          req_first;
   logic [NREQ-1:0]          req_last;
   logic [NREQ*NOF_BITS-1:0] req_data;
   logic [NREQ-1:0]          gnt;
   logic [NREQ-1:0]          rsp_valid;
   logic [NREQ-1:0]          rsp_to;
   logic [NOF_BITS:0]        rsp_data;
   logic                     avg_start;
   logic                     avg_first;
   logic                     avg_last;
   logic [NOF_BITS-1:0]      avg_data;
   logic                     avg_busy;
   logic                     avg_TO;
   logic                     avg_done;
   logic [NOF_BITS:0]        avg_data_out;

   modport slave (
      input  req, req_first, req_last, req_data,
      input  avg_busy, avg_TO, avg_done, avg_data_out,
      output gnt, rsp_valid, rsp_to, rsp_data,
      output avg_start, avg_first, avg_last, avg_data
   );

   modport master (
      output req, req_first, req_last, req_data,
      output avg_busy, avg_TO, avg_done, avg_data_out,
      input  gnt, rsp_valid, rsp_to, rsp_data,
      input  avg_start, avg_first, avg_last, avg_data
   );
endinterface

// File: rtl/avg_rr_sched.sv
// Round-robin scheduler sharing one streaming average engine among NREQ requesters,
// with result/timeout routing back to the owner and an optional ACTIVE-state watchdog.
module avg_rr_sched #(
   parameter int unsigned NOF_BITS = 32,
   parameter int unsigned NREQ     = 4,
   parameter int unsigned WDOG_CYC = 1024
) (
   input logic          clk,
   input logic          rst_n,
   avg_rr_sched_if.slave bus
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned SW = PW + 1;
   localparam int unsigned WW = (WDOG_CYC > 1) ? $clog2(WDOG_CYC + 1) : 1;
   localparam logic [WW-1:0] WDOG_LAST = (WDOG_CYC > 0) ? WW'(WDOG_CYC - 1) : '0;
   localparam logic [PW-1:0] LAST_IDX  = PW'(NREQ - 1);
   localparam logic [SW-1:0] NREQ_S    = SW'(NREQ);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_ACTIVE,
      S_DRAIN
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [NREQ-1:0]     r_gnt;
   logic [NREQ-1:0]     r_rsp_valid;
   logic [NREQ-1:0]     r_rsp_to;
   logic [NOF_BITS:0]   r_rsp_data;
   logic [PW-1:0]       r_ptr;
   logic [PW-1:0]       r_owner;
   logic [WW-1:0]       r_wdog;

   logic                w_found;
   logic [PW-1:0]       w_win;
   logic [SW-1:0]       w_sum;
   logic [PW-1:0]       w_idx;
   logic                w_active;
   logic                w_wdog_hit;
   logic                w_grant;
   logic                w_take_done;
   logic                w_take_to;
   logic                w_release;

   assign w_active   = (r_state == S_ACTIVE);
   assign w_wdog_hit = (WDOG_CYC != 0) && w_active && (r_wdog == WDOG_LAST);

   // First pending request at or above ptr, wrapping at NREQ rather than 2**PW.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      w_idx   = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         w_sum = {1'b0, r_ptr} + SW'(i);
         if (w_sum >= NREQ_S) begin
            w_sum = w_sum - NREQ_S;
         end
         w_idx = w_sum[PW-1:0];
         if (!w_found && bus.req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Result beats timeout when both land in the same ACTIVE cycle.
   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_take_done = 1'b0;
      w_take_to   = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_grant     = 1'b1;
               w_state_nxt = S_START;
            end
         end
         S_START: begin
            w_state_nxt = S_ACTIVE;
         end
         S_ACTIVE: begin
            if (bus.avg_done) begin
               w_take_done = 1'b1;
               w_state_nxt = S_DRAIN;
            end else if (bus.avg_TO || w_wdog_hit) begin
               w_take_to   = 1'b1;
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!bus.avg_busy) begin
               w_release   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_gnt       <= '0;
         r_rsp_valid <= '0;
         r_rsp_to    <= '0;
         r_rsp_data  <= '0;
         r_ptr       <= '0;
         r_owner     <= '0;
         r_wdog      <= '0;
      end else begin
         r_rsp_valid <= '0;
         r_rsp_to    <= '0;
         if (w_active) begin
            r_wdog <= r_wdog + 1'b1;
         end else begin
            r_wdog <= '0;
         end
         if (w_grant) begin
            r_gnt   <= NREQ'(1) << w_win;
            r_owner <= w_win;
         end
         if (w_take_done) begin
            r_rsp_data  <= bus.avg_data_out;
            r_rsp_valid <= r_gnt;
         end
         if (w_take_to) begin
            r_rsp_to <= r_gnt;
         end
         if (w_release) begin
            r_gnt <= '0;
            r_ptr <= (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
         end
      end
   end

   always_comb begin
      bus.avg_first = 1'b0;
      bus.avg_last  = 1'b0;
      bus.avg_data  = '0;
      if (w_active) begin
         bus.avg_first = bus.req_first[r_owner];
         bus.avg_last  = bus.req_last[r_owner];
         bus.avg_data  = bus.req_data[r_owner*NOF_BITS +: NOF_BITS];
      end
   end

   assign bus.avg_start = (r_state == S_START);
   assign bus.gnt       = r_gnt;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_to    = r_rsp_to;
   assign bus.rsp_data  = r_rsp_data;

endmodule

// File: tb/tb_avg_rr_sched.sv
// Directed bench for avg_rr_sched with a small behavioural average engine on the far side.
`timescale 1ns/1ps
module tb_avg_rr_sched;
   localparam int unsigned NB = 16;
   localparam int unsigned NR = 4;
   localparam int unsigned WD = 20;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   avg_rr_sched_if #(.NOF_BITS(NB), .NREQ(NR)) bus ();

   avg_rr_sched #(.NOF_BITS(NB), .NREQ(NR), .WDOG_CYC(WD)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int n_vec = 0, n_err = 0;
   int n_start = 0, n_valid = 0, n_to = 0, n_overlap = 0;

   // Engine model: mode 0 averages, 1 times out after 5 busy cycles,
   // 2 signals done and TO together, 3 stays busy until e_release.
   int          e_mode = 0;
   logic        e_release = 1'b0;
   logic        e_busy, e_done, e_to;
   logic [31:0] e_sum, e_cnt, e_tcnt, w_sum_n, w_cnt_n;
   logic [NB:0] e_res;

   assign w_sum_n = (bus.avg_first ? 32'd0 : e_sum) + 32'(bus.avg_data);
   assign w_cnt_n = bus.avg_first ? 32'd1 : e_cnt + 32'd1;
   assign bus.avg_busy     = e_busy;
   assign bus.avg_done     = e_done;
   assign bus.avg_TO       = e_to;
   assign bus.avg_data_out = e_res;

   always @(posedge clk) begin
      e_done <= 1'b0;
      e_to   <= 1'b0;
      if (!rst_n) begin
         e_busy <= 1'b0; e_sum <= '0; e_cnt <= '0; e_tcnt <= '0; e_res <= '0;
      end else if (bus.avg_start) begin
         e_busy <= 1'b1; e_sum <= '0; e_cnt <= '0; e_tcnt <= '0;
      end else if (e_busy) begin
         e_tcnt <= e_tcnt + 32'd1;
         if (e_mode == 3) begin
            if (e_release) e_busy <= 1'b0;
         end else if (e_mode == 1) begin
            if (e_tcnt == 32'd4) begin e_to <= 1'b1; e_busy <= 1'b0; end
         end else if (bus.avg_first || e_cnt != 0) begin
            e_sum <= w_sum_n;
            e_cnt <= w_cnt_n;
            if (bus.avg_last) begin
               e_res  <= (NB+1)'(w_sum_n / w_cnt_n);
               e_done <= 1'b1;
               e_busy <= 1'b0;
               e_to   <= (e_mode == 2);
            end
         end
      end
   end

   always @(negedge clk) begin
      #1;
      if ($countones(bus.gnt) > 1) n_overlap++;
      n_valid += $countones(bus.rsp_valid);
      n_to    += $countones(bus.rsp_to);
      if (bus.avg_start) n_start++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_stream();
      bus.req_first = '0;
      bus.req_last  = '0;
      bus.req_data  = '0;
   endtask

   task automatic wait_start(input string tag);
      int k = 0;
      while (bus.avg_start !== 1'b1 && k < 40) begin @(negedge clk); k++; end
      chk(tag, 32'(bus.avg_start), 32'd1);
   endtask

   task automatic wait_rsp(input string tag);
      int k = 0;
      while (bus.rsp_valid == '0 && bus.rsp_to == '0 && k < 40) begin @(negedge clk); k++; end
      chk(tag, 32'(k < 40), 32'd1);
   endtask

   // Owner streams four samples; every other requester holds first/last high with
   // all-ones data so any leak through the mux corrupts the average.
   task automatic serve(input int unsigned idx, input logic [15:0] d0, d1, d2, d3,
                        input logic [NB:0] exp, input string tag);
      logic [63:0]    dv;
      logic [NR-1:0]  oh;
      dv = {d3, d2, d1, d0};
      oh = NR'(1) << idx;
      wait_start({tag, "_start"});
      chk({tag, "_gnt"}, 32'(bus.gnt), 32'(oh));
      for (int s = 0; s < 4; s++) begin
         @(negedge clk);
         bus.req_first = ~oh | ((s == 0) ? oh : '0);
         bus.req_last  = ~oh | ((s == 3) ? oh : '0);
         for (int j = 0; j < int'(NR); j++) begin
            bus.req_data[j*NB +: NB] = (j == int'(idx)) ? dv[s*16 +: 16] : 16'hFFFF;
         end
         if (s == 0) begin
            #1;
            chk({tag, "_mux_data"}, 32'(bus.avg_data), 32'(d0));
            chk({tag, "_mux_first"}, 32'(bus.avg_first), 32'd1);
         end
      end
      @(negedge clk);
      clear_stream();
      wait_rsp({tag, "_rsp"});
      chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'(oh));
      chk({tag, "_data"}, 32'(bus.rsp_data), 32'(exp));
   endtask

   initial begin
      int s0, v0, t0, o0, k;
      bus.req = '0;
      clear_stream();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_gnt", 32'(bus.gnt), 32'd0);
      chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_to", 32'(bus.rsp_to), 32'd0);
      chk("rst_data", 32'(bus.rsp_data), 32'd0);
      chk("rst_start", 32'(bus.avg_start), 32'd0);
      chk("rst_first", 32'(bus.avg_first), 32'd0);
      chk("rst_last", 32'(bus.avg_last), 32'd0);
      chk("rst_avg_data", 32'(bus.avg_data), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single requester, 1-cycle latency, req dropped while granted
      s0 = n_start;
      bus.req = 4'b0001;
      @(negedge clk);
      chk("t1_latency", 32'(bus.avg_start), 32'd1);
      chk("t1_gnt_with_start", 32'(bus.gnt), 32'd1);
      bus.req = '0;
      serve(0, 16'd4, 16'd8, 16'd12, 16'd16, 17'd10, "t1");
      @(negedge clk);
      chk("t1_gnt_clear", 32'(bus.gnt), 32'd0);
      chk("t1_valid_1cyc", 32'(bus.rsp_valid), 32'd0);
      repeat (3) @(negedge clk);
      chk("t1_data_hold", 32'(bus.rsp_data), 32'd10);
      chk("t1_one_start", 32'(n_start - s0), 32'd1);

      // Contention from reset: order 0,1,3,0
      rst_n = 1'b0;
      bus.req = 4'b1011;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      s0 = n_start;
      o0 = n_overlap;
      serve(0, 16'd1, 16'd1, 16'd1, 16'd1, 17'd1, "c0");
      serve(1, 16'd1, 16'd2, 16'd3, 16'd4, 17'd2, "c1");
      serve(3, 16'd100, 16'd200, 16'd300, 16'd400, 17'd250, "c3");
      serve(0, 16'd5, 16'd5, 16'd5, 16'd6, 17'd5, "c0b");
      bus.req = '0;
      repeat (3) @(negedge clk);
      chk("c_starts", 32'(n_start - s0), 32'd4);
      chk("c_no_overlap", 32'(n_overlap - o0), 32'd0);
      chk("c_gnt_idle", 32'(bus.gnt), 32'd0);

      // Engine timeout on requester 2 (ptr=1), requester 0 pending
      e_mode = 1;
      bus.req = 4'b0100;
      wait_start("to_start");
      chk("to_gnt", 32'(bus.gnt), 32'h4);
      bus.req = 4'b0001;
      v0 = n_valid;
      t0 = n_to;
      wait_rsp("to_rsp");
      chk("to_pulse", 32'(bus.rsp_to), 32'h4);
      chk("to_no_valid", 32'(bus.rsp_valid), 32'd0);
      e_mode = 0;
      serve(0, 16'd2, 16'd4, 16'd6, 16'd8, 17'd5, "to_next");
      bus.req = '0;
      repeat (2) @(negedge clk);
      chk("to_once", 32'(n_to - t0), 32'd1);
      chk("to_valid_cnt", 32'(n_valid - v0), 32'd1);

      // done and TO together (ptr=1)
      e_mode = 2;
      t0 = n_to;
      bus.req = 4'b0010;
      serve(1, 16'd7, 16'd7, 16'd7, 16'd7, 17'd7, "both");
      bus.req = '0;
      repeat (2) @(negedge clk);
      chk("both_no_to", 32'(n_to - t0), 32'd0);
      e_mode = 0;

      // Watchdog with a hung engine (ptr=2, search wraps to 1)
      e_mode = 3;
      t0 = n_to;
      bus.req = 4'b0010;
      wait_start("wd_start");
      chk("wd_gnt", 32'(bus.gnt), 32'h2);
      bus.req = '0;
      repeat (20) @(negedge clk);
      chk("wd_pre", 32'(bus.rsp_to), 32'd0);
      @(negedge clk);
      chk("wd_fire", 32'(bus.rsp_to), 32'h2);
      repeat (4) @(negedge clk);
      chk("wd_hold_gnt", 32'(bus.gnt), 32'h2);
      chk("wd_once", 32'(n_to - t0), 32'd1);
      e_release = 1'b1;
      k = 0;
      while (bus.gnt !== '0 && k < 20) begin @(negedge clk); k++; end
      chk("wd_release", 32'(bus.gnt), 32'd0);
      e_release = 1'b0;
      e_mode = 0;

      // Reset mid-ACTIVE on requester 2 (ptr=2); afterwards ptr restarts at 0
      bus.req = 4'b0100;
      wait_start("rm_start");
      chk("rm_gnt", 32'(bus.gnt), 32'h4);
      @(negedge clk);
      bus.req_first = 4'b0100;
      bus.req_data[2*NB +: NB] = 16'd50;
      @(negedge clk);
      bus.req_first = '0;
      bus.req_data[2*NB +: NB] = 16'd60;
      rst_n = 1'b0;
      v0 = n_valid;
      t0 = n_to;
      @(negedge clk);
      chk("rm_gnt0", 32'(bus.gnt), 32'd0);
      chk("rm_valid0", 32'(bus.rsp_valid), 32'd0);
      chk("rm_to0", 32'(bus.rsp_to), 32'd0);
      chk("rm_data0", 32'(bus.avg_data), 32'd0);
      clear_stream();
      bus.req = 4'b1010;
      @(negedge clk);
      rst_n = 1'b1;
      serve(1, 16'd10, 16'd20, 16'd30, 16'd40, 17'd25, "rm_r1");
      bus.req = 4'b1000;
      serve(3, 16'd3, 16'd3, 16'd3, 16'd3, 17'd3, "rm_r3");
      bus.req = '0;
      repeat (3) @(negedge clk);
      chk("rm_valid_cnt", 32'(n_valid - v0), 32'd2);
      chk("rm_to_cnt", 32'(n_to - t0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
